// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter sharing one bank of edge-triggered SR bits between NREQ requesters.
// A request is granted at the edge leaving IDLE and its command lands at the edge ending APPLY.
module sr_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3
) (
    input  logic                 cp,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      s_in,
    input  logic [NREQ-1:0]      r_in,
    input  logic [NREQ*IDXW-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic [NBITS-1:0]     q,
    output logic [NBITS-1:0]     qbar,
    output logic                 done,
    output logic                 err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDXW:0] NBITS_W = (IDXW + 1)'(NBITS);
    localparam logic [PW:0]   NREQ_W  = (PW + 1)'(NREQ);

    typedef enum logic {IDLE, APPLY} state_t;

    state_t           state_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    win_q;
    logic             s_q, r_q;
    logic [IDXW-1:0]  idx_q;
    logic [NREQ-1:0]  gnt_q;
    logic             done_q, err_q;
    logic [NBITS-1:0] bank_q;

    logic [2*NREQ-1:0] rot;
    logic [PW-1:0]     off;
    logic [PW:0]       sum;
    logic [PW-1:0]     win_d;
    logic              s_d, r_d, err_d;
    logic [IDXW-1:0]   idx_d;
    logic [NREQ-1:0]   gnt_d;
    logic [PW-1:0]     ptr_d;
    logic [NBITS-1:0]  bank_d;

    // Rotate requests so bit 0 is the pointer position; the lowest set bit is the winner.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        rot = {req, req} >> ptr_q;
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = PW'(i);
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        win_d = sum[PW-1:0];

        s_d   = 1'b0;
        r_d   = 1'b0;
        idx_d = '0;
        gnt_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_d == PW'(k)) begin
                s_d      = s_in[k];
                r_d      = r_in[k];
                idx_d    = idx[k*IDXW +: IDXW];
                gnt_d[k] = 1'b1;
            end
        end
        err_d = ({1'b0, idx_d} >= NBITS_W);
        ptr_d = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
    end

    // Latched command applied to the addressed bit; an out-of-range index leaves the bank alone.
    always_comb begin
        bank_d = bank_q;
        for (int b = 0; b < NBITS; b++) begin
            if (!err_q && idx_q == IDXW'(b)) begin
                case ({s_q, r_q})
                    2'b10:   bank_d[b] = 1'b1;
                    2'b01:   bank_d[b] = 1'b0;
                    2'b11:   bank_d[b] = ~bank_q[b];
                    default: bank_d[b] = bank_q[b];
                endcase
            end
        end
    end

    always_ff @(posedge cp or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            idx_q   <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bank_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (state_q)
                IDLE: begin
                    gnt_q  <= '0;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (|req) begin
                        win_q   <= win_d;
                        s_q     <= s_d;
                        r_q     <= r_d;
                        idx_q   <= idx_d;
                        gnt_q   <= gnt_d;
                        done_q  <= 1'b1;
                        err_q   <= err_d;
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    bank_q  <= bank_d;
                    ptr_q   <= ptr_d;
                    gnt_q   <= '0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign err  = err_q;
    assign q    = bank_q;
    assign qbar = ~bank_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Self-checking bench for sr_bank_arbiter: an 8-bit bank for the main table and sequences,
// plus a 6-bit bank sharing the same inputs for the out-of-range index case.
module tb_sr_bank_arbiter;

    logic        cp = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0, s_in = '0, r_in = '0;
    logic [11:0] idx = '0;

    logic [3:0]  gnt, gnt6;
    logic [7:0]  q, qbar;
    logic [5:0]  q6, qbar6;
    logic        done, err, done6, err6;

    sr_bank_arbiter #(.NREQ(4), .NBITS(8), .IDXW(3)) u_dut (
        .cp(cp), .rst(rst), .req(req), .s_in(s_in), .r_in(r_in), .idx(idx),
        .gnt(gnt), .q(q), .qbar(qbar), .done(done), .err(err)
    );

    sr_bank_arbiter #(.NREQ(4), .NBITS(6), .IDXW(3)) u_dut6 (
        .cp(cp), .rst(rst), .req(req), .s_in(s_in), .r_in(r_in), .idx(idx),
        .gnt(gnt6), .q(q6), .qbar(qbar6), .done(done6), .err(err6)
    );

    always #5 cp = ~cp;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] gnt;
        logic       err;
        logic [7:0] q;
    } exp_t;

    typedef struct {
        logic [3:0]  req, s, r;
        logic [11:0] idx;
        logic [3:0]  gnt;
        logic        err;
        logic [7:0]  q;
    } vec_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pk(input int i3, input int i2, input int i1, input int i0);
        return {3'(i3), 3'(i2), 3'(i1), 3'(i0)};
    endfunction

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; s_in = '0; r_in = '0; idx = '0;
        step();
        step();
        check("rst.gnt",   gnt,   0);
        check("rst.q",     q,     0);
        check("rst.qbar",  qbar,  8'hFF);
        check("rst.done",  done,  0);
        check("rst.err",   err,   0);
        check("rst.qbar6", qbar6, 6'h3F);
        rst = 1'b1;
    endtask

    // One complete command from IDLE: grant/done/err in APPLY, bank result one edge later.
    task automatic issue(input logic [3:0] rq, input logic [3:0] s, input logic [3:0] r,
                         input logic [11:0] ix, input logic [3:0] eg, input logic ee,
                         input logic [7:0] eq, input string tag);
        exp_t       e;
        logic [7:0] nq;
        req = rq; s_in = s; r_in = r; idx = ix;
        sb.push_back('{gnt: eg, err: ee, q: eq});
        step();
        req = '0;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, ".gnt"},  gnt,  e.gnt);
        check({tag, ".done"}, done, 1);
        check({tag, ".err"},  err,  e.err);
        step();
        nq = ~e.q;
        check({tag, ".q"},      q,    e.q);
        check({tag, ".qbar"},   qbar, nq);
        check({tag, ".gnt0"},   gnt,  0);
        check({tag, ".done0"},  done, 0);
    endtask

    vec_t vecs[8];
    exp_t e;
    logic [7:0] acc;

    initial begin
        vecs[0] = '{4'b0001, 4'b0001, 4'b0000, pk(0,0,0,3), 4'b0001, 1'b0, 8'h08};
        vecs[1] = '{4'b0100, 4'b0100, 4'b0100, pk(0,3,0,0), 4'b0100, 1'b0, 8'h00};
        vecs[2] = '{4'b0100, 4'b0100, 4'b0100, pk(0,3,0,0), 4'b0100, 1'b0, 8'h08};
        vecs[3] = '{4'b1111, 4'b0000, 4'b0000, pk(5,5,5,5), 4'b1000, 1'b0, 8'h08};
        vecs[4] = '{4'b0110, 4'b0110, 4'b0000, pk(0,7,0,0), 4'b0010, 1'b0, 8'h09};
        vecs[5] = '{4'b0110, 4'b0110, 4'b0000, pk(0,7,0,0), 4'b0100, 1'b0, 8'h89};
        vecs[6] = '{4'b0011, 4'b0000, 4'b0001, pk(0,0,0,3), 4'b0001, 1'b0, 8'h81};
        vecs[7] = '{4'b1001, 4'b1000, 4'b1000, pk(0,0,0,0), 4'b1000, 1'b0, 8'h80};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].req, vecs[i].s, vecs[i].r, vecs[i].idx,
                  vecs[i].gnt, vecs[i].err, vecs[i].q, $sformatf("vec%0d", i));
        end

        // Held requests with hold commands rotate one grant every two cycles.
        do_reset();
        req = 4'b1111; s_in = '0; r_in = '0; idx = '0;
        sb.push_back('{gnt: 4'b0001, err: 1'b0, q: 8'h00});
        sb.push_back('{gnt: 4'b0000, err: 1'b0, q: 8'h00});
        sb.push_back('{gnt: 4'b0010, err: 1'b0, q: 8'h00});
        sb.push_back('{gnt: 4'b0000, err: 1'b0, q: 8'h00});
        sb.push_back('{gnt: 4'b0100, err: 1'b0, q: 8'h00});
        sb.push_back('{gnt: 4'b0000, err: 1'b0, q: 8'h00});
        sb.push_back('{gnt: 4'b1000, err: 1'b0, q: 8'h00});
        sb.push_back('{gnt: 4'b0000, err: 1'b0, q: 8'h00});
        sb.push_back('{gnt: 4'b0001, err: 1'b0, q: 8'h00});
        sb.push_back('{gnt: 4'b0000, err: 1'b0, q: 8'h00});
        for (int c = 0; c < 10; c++) begin
            step();
            e = sb.pop_front();
            check($sformatf("rr.gnt%0d", c), gnt, e.gnt);
            check($sformatf("rr.q%0d", c),   q,   e.q);
        end
        req = '0;
        step();

        // Out-of-range index on the 6-bit bank: err with done, no change, pointer still advances.
        do_reset();
        req = 4'b0010; s_in = 4'b0010; r_in = '0; idx = pk(0,0,7,0);
        step();
        req = '0;
        check("err6.gnt",  gnt6,  4'b0010);
        check("err6.done", done6, 1);
        check("err6.err",  err6,  1);
        check("err8.err",  err,   0);
        step();
        check("err6.q",    q6,    0);
        check("err6.qbar", qbar6, 6'h3F);
        req = 4'b0110; s_in = '0; r_in = '0; idx = '0;
        step();
        req = '0;
        check("err6.ptr", gnt6, 4'b0100);
        step();

        // Reset during APPLY drops the command and returns the pointer to 0.
        do_reset();
        issue(4'b0010, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0010, 1'b0, 8'h00, "pre");
        req = 4'b0100; s_in = 4'b0100; r_in = '0; idx = pk(0,5,0,0);
        step();
        req = '0;
        check("mid.gnt", gnt, 4'b0100);
        #2 rst = 1'b0;
        #1;
        check("mid.q",    q,    0);
        check("mid.qbar", qbar, 8'hFF);
        check("mid.gnt0", gnt,  0);
        check("mid.done", done, 0);
        step();
        step();
        rst = 1'b1;
        step();
        check("post.q",   q,   0);
        check("post.gnt", gnt, 0);
        issue(4'b1001, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0001, 1'b0, 8'h00, "post");

        // Fill the bank, then show inputs changed during APPLY are ignored.
        do_reset();
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            acc[i] = 1'b1;
            issue(4'b0001, 4'b0001, 4'b0000, pk(0,0,0,i), 4'b0001, 1'b0, acc,
                  $sformatf("fill%0d", i));
        end
        req = 4'b1001; s_in = 4'b0000; r_in = 4'b1000; idx = pk(0,0,0,4);
        step();
        check("samp.gnt3", gnt, 4'b1000);
        req = 4'b0001; s_in = 4'b1000; r_in = 4'b1001; idx = pk(1,0,0,6);
        step();
        check("samp.q3",    q,    8'hFE);
        check("samp.qbar3", qbar, 8'h01);
        step();
        req = '0;
        check("samp.gnt0", gnt, 4'b0001);
        step();
        check("samp.q0", q, 8'hBE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
